// File: rtl/vadd_rd_burst_issuer.sv
// AXI4 read-address burst issuer: splits (offset, size) into fixed-length AR bursts,
// limits bursts in flight to C_MAX_OUTSTANDING and pulses ctrl_done after the last RLAST.
module vadd_rd_burst_issuer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BYTES_PER_BEAT  = 64,
  parameter int C_BURST_LEN       = 16,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic                                   ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]                ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]           ctrl_xfer_size_in_bytes,
  output logic                                   ctrl_done,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]                m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  input  logic                                   m_axi_rvalid,
  input  logic                                   m_axi_rready,
  input  logic                                   m_axi_rlast,
  output logic [2:0]                             dbg_state_o,
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] dbg_outstanding_o
);

  localparam int CW      = C_XFER_SIZE_WIDTH + 1;
  localparam int OW      = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int BEAT_SH = $clog2(C_BYTES_PER_BEAT);
  localparam int LEN_SH  = $clog2(C_BURST_LEN);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * C_BYTES_PER_BEAT);
  localparam logic [OW-1:0]           MAX_OUT     = OW'(C_MAX_OUTSTANDING);
  localparam logic [7:0]              FULL_ARLEN  = 8'(C_BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                         state_q;
  logic [C_XFER_SIZE_WIDTH-1:0]   size_q;
  logic [C_ADDR_WIDTH-1:0]        araddr_q;
  logic [7:0]                     arlen_q;
  logic [7:0]                     last_arlen_q;
  logic                           arvalid_q;
  logic                           done_q;
  logic [OW-1:0]                  outstanding_q, outstanding_d;
  logic [CW-1:0]                  remaining_q, remaining_d;

  logic [CW-1:0] beats, bursts, beats_m1;
  logic [7:0]    last_arlen;
  logic          ar_hs, r_hs, busy, dec;

  // One extra bit of width keeps size + (bytes_per_beat-1) from wrapping at the top of the range.
  always_comb begin
    beats      = (CW'(size_q) + CW'(C_BYTES_PER_BEAT - 1)) >> BEAT_SH;
    bursts     = (beats + CW'(C_BURST_LEN - 1)) >> LEN_SH;
    beats_m1   = beats - CW'(1);
    last_arlen = 8'(beats_m1 & CW'(C_BURST_LEN - 1));
  end

  // AR transfers on a cycle with arvalid & arready high; arvalid/araddr/arlen are held
  // until that cycle. An RLAST counts only when rvalid & rready & rlast are all high.
  assign ar_hs = arvalid_q & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign busy  = (state_q == S_CALC) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign dec   = r_hs & busy & (outstanding_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    case ({ar_hs, dec})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    remaining_d = ar_hs ? (remaining_q - CW'(1)) : remaining_q;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q       <= S_IDLE;
      size_q        <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      last_arlen_q  <= '0;
      arvalid_q     <= 1'b0;
      done_q        <= 1'b0;
      outstanding_q <= '0;
      remaining_q   <= '0;
    end else begin
      done_q        <= 1'b0;
      outstanding_q <= outstanding_d;
      remaining_q   <= remaining_d;
      if (ar_hs) begin
        araddr_q <= araddr_q + BURST_BYTES;
        arlen_q  <= (remaining_d == CW'(1)) ? last_arlen_q : FULL_ARLEN;
      end
      case (state_q)
        S_IDLE: begin
          if (ctrl_start) begin
            size_q   <= ctrl_xfer_size_in_bytes;
            araddr_q <= ctrl_addr_offset;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          remaining_q  <= bursts;
          last_arlen_q <= last_arlen;
          arlen_q      <= (bursts == CW'(1)) ? last_arlen : FULL_ARLEN;
          if (beats == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_ISSUE;
            arvalid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Credit is judged on next cycle's registered count, so a fresh RLAST frees it one cycle later.
          if (remaining_d == '0) begin
            state_q   <= S_DRAIN;
            arvalid_q <= 1'b0;
          end else begin
            arvalid_q <= (outstanding_d < MAX_OUT);
          end
        end
        S_DRAIN: begin
          if (outstanding_d == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctrl_done         = done_q;
  assign m_axi_arvalid     = arvalid_q;
  assign m_axi_araddr      = araddr_q;
  assign m_axi_arlen       = arlen_q;
  assign dbg_state_o       = state_q;
  assign dbg_outstanding_o = outstanding_q;

endmodule

// File: tb/tb_vadd_rd_burst_issuer.sv
// Bench for vadd_rd_burst_issuer: burst-list model with per-cycle compare, directed scenarios
// with literal expectations, and an R-channel responder.
module tb_vadd_rd_burst_issuer;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        ap_rst_n;
  logic        ctrl_start;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes;
  logic        ctrl_done;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        m_axi_rlast;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_outstanding;

  vadd_rd_burst_issuer #(
    .C_ADDR_WIDTH(64), .C_XFER_SIZE_WIDTH(32), .C_BYTES_PER_BEAT(64),
    .C_BURST_LEN(16), .C_MAX_OUTSTANDING(MAXO)
  ) dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .ctrl_start(ctrl_start),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_done(ctrl_done), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast), .dbg_state_o(dbg_state),
    .dbg_outstanding_o(dbg_outstanding)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: expected AR list {addr, arlen}, refilled lazily from the transfer description
  logic [71:0]     exp_q[$];
  longint unsigned m_base, m_beats, m_bursts, m_gen;
  bit              m_busy = 1'b0;
  int              m_wait = 0;
  int              m_out = 0;
  bit              exp_done_next = 1'b0;
  bit              mon_en = 1'b0;
  bit              prev_stall = 1'b0;
  logic [63:0]     prev_addr;
  logic [7:0]      prev_len;
  logic [63:0]     hs_addr[$];
  logic [7:0]      hs_len[$];
  int              hs_cyc[$];
  int              done_count = 0;
  int              done_cyc = 0;
  int              r_due_q[$];
  bit              auto_r = 1'b0;
  bit              drain_mode = 1'b0;

  task automatic refill();
    logic [63:0] a;
    logic [7:0]  l;
    while (exp_q.size() < 4 && m_gen < m_bursts) begin
      a = m_base + m_gen * 64'd1024;
      if (m_gen == m_bursts - 1) l = 8'(m_beats - (m_bursts - 1) * 16 - 1);
      else l = 8'd15;
      exp_q.push_back({a, l});
      m_gen++;
    end
  endtask

  task automatic monitor_step();
    bit exp_arv, hs, dec, done_cur, accept;
    logic [71:0] front;
    done_cur = exp_done_next;
    exp_arv  = m_busy && (m_wait == 0) && (exp_q.size() > 0) && (m_out < MAXO);
    check("arvalid", 64'(m_axi_arvalid), 64'(exp_arv));
    check("ctrl_done", 64'(ctrl_done), 64'(done_cur));
    check("outstanding", 64'(dbg_outstanding), 64'(m_out));
    if (prev_stall) begin
      check("ar_hold_addr", m_axi_araddr, prev_addr);
      check("ar_hold_len", 64'(m_axi_arlen), 64'(prev_len));
    end
    if (ctrl_done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    prev_stall = (m_axi_arvalid === 1'b1) && (m_axi_arready === 1'b0) && (ap_rst_n === 1'b1);
    prev_addr  = m_axi_araddr;
    prev_len   = m_axi_arlen;
    if (!ap_rst_n) begin
      m_busy = 1'b0; m_wait = 0; m_out = 0; m_gen = 0; m_bursts = 0;
      exp_q.delete();
      exp_done_next = 1'b0;
    end else begin
      hs     = exp_arv && m_axi_arready;
      dec    = m_axi_rvalid && m_axi_rready && m_axi_rlast && m_busy && (m_out > 0);
      accept = ctrl_start && !m_busy && !done_cur;
      if (hs) begin
        front = exp_q.pop_front();
        check("ar_addr", m_axi_araddr, front[71:8]);
        check("ar_len", 64'(m_axi_arlen), 64'(front[7:0]));
        hs_addr.push_back(m_axi_araddr);
        hs_len.push_back(m_axi_arlen);
        hs_cyc.push_back(cyc);
        if (auto_r) r_due_q.push_back(cyc + 10);
        refill();
        m_out++;
      end
      if (dec) m_out--;
      exp_done_next = 1'b0;
      if (m_busy) begin
        if ((m_wait == 1 && m_bursts == 0) ||
            (m_wait == 0 && exp_q.size() == 0 && m_gen == m_bursts && m_out == 0)) begin
          exp_done_next = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (m_wait > 0) m_wait--;
      if (accept) begin
        m_base   = ctrl_addr_offset;
        m_beats  = (64'(ctrl_xfer_size_in_bytes) + 64'd63) / 64;
        m_bursts = (m_beats + 64'd15) / 16;
        m_gen    = 0;
        exp_q.delete();
        refill();
        m_busy = 1'b1;
        m_wait = 1;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) monitor_step();
  end

  // R-channel responder: RLAST pulses on scheduled cycles, or every cycle while draining
  initial begin
    bit hit;
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      hit = 1'b0;
      for (int i = 0; i < r_due_q.size(); i++) begin
        if (r_due_q[i] == cyc) begin
          hit = 1'b1;
          r_due_q.delete(i);
          break;
        end
      end
      if (drain_mode && m_out > 0) hit = 1'b1;
      m_axi_rvalid = hit;
      m_axi_rlast  = hit;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    hs_addr.delete();
    hs_len.delete();
    hs_cyc.delete();
  endtask

  task automatic start_xfer(input logic [63:0] off, input logic [31:0] sz, output int t0);
    ctrl_start = 1'b1;
    ctrl_addr_offset = off;
    ctrl_xfer_size_in_bytes = sz;
    t0 = cyc;
    step();
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d, n;
    d = done_count;
    n = 0;
    while (done_count == d && n < budget) begin
      step();
      n++;
    end
    check({name, "_done_seen"}, 64'(done_count != d), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check({name, "_araddr"}, m_axi_araddr, 64'd0);
    check({name, "_arlen"}, 64'(m_axi_arlen), 64'd0);
    check({name, "_done"}, 64'(ctrl_done), 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'd0);
    check({name, "_outstanding"}, 64'(dbg_outstanding), 64'd0);
  endtask

  // full transfer with arready=1 and RLAST 10 cycles after each AR
  task automatic run_xfer(input logic [63:0] off, input logic [31:0] sz, input int exp_n,
                          input logic [7:0] exp_last_len, input int exp_done_dt, input string name);
    int t0;
    clr_logs();
    auto_r = 1'b1;
    m_axi_arready = 1'b1;
    start_xfer(off, sz, t0);
    wait_done(200, name);
    check({name, "_n_ar"}, 64'(hs_addr.size()), 64'(exp_n));
    if (hs_addr.size() == exp_n) begin
      for (int i = 0; i < exp_n; i++) begin
        check($sformatf("%s_addr%0d", name, i), hs_addr[i], off + 64'(i) * 64'h400);
        check($sformatf("%s_len%0d", name, i), 64'(hs_len[i]),
              (i == exp_n - 1) ? 64'(exp_last_len) : 64'd15);
        check($sformatf("%s_cyc%0d", name, i), 64'(hs_cyc[i]), 64'(t0 + 2 + i));
      end
    end
    check({name, "_done_cycle"}, 64'(done_cyc - t0), 64'(exp_done_dt));
  endtask

  initial begin
    int t0, d;
    ap_rst_n = 1'b0;
    ctrl_start = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_xfer_size_in_bytes = '0;
    m_axi_arready = 1'b1;
    step(); step(); step();
    check_reset_outputs("reset");
    ap_rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    run_xfer(64'h1000, 32'd4096, 4, 8'd15, 16, "t1_4k");
    run_xfer(64'h20000, 32'd1100, 2, 8'd1, 14, "t2_1100");
    run_xfer(64'h30000, 32'd1025, 2, 8'd0, 14, "t2_1025");
    run_xfer(64'h4000, 32'd1, 1, 8'd0, 13, "t2_1");
    run_xfer(64'h5000, 32'd0, 0, 8'd0, 2, "t2_0");

    // AR backpressure for 5 cycles after arvalid rises
    clr_logs();
    auto_r = 1'b1;
    m_axi_arready = 1'b0;
    start_xfer(64'h8000, 32'd2048, t0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t3_arvalid_hold", 64'(m_axi_arvalid), 64'd1);
      check("t3_araddr_hold", m_axi_araddr, 64'h8000);
      check("t3_arlen_hold", 64'(m_axi_arlen), 64'd15);
      step();
    end
    m_axi_arready = 1'b1;
    wait_done(200, "t3");
    check("t3_n_ar", 64'(hs_addr.size()), 64'd2);
    if (hs_addr.size() == 2) begin
      check("t3_first_hs_cycle", 64'(hs_cyc[0] - t0), 64'd7);
      check("t3_addr1", hs_addr[1], 64'h8400);
    end

    // credit limit, same-cycle AR+RLAST, ignored start while busy
    clr_logs();
    auto_r = 1'b0;
    m_axi_arready = 1'b1;
    start_xfer(64'h100000, 32'd8192, t0);
    repeat (9) step();
    check("t4_n_ar_at_limit", 64'(hs_addr.size()), 64'd4);
    check("t4_arvalid_blocked", 64'(m_axi_arvalid), 64'd0);
    r_due_q.push_back(cyc);
    step();
    check("t4_arvalid_after_rlast", 64'(m_axi_arvalid), 64'd1);
    step();
    check("t4_arvalid_reblocked", 64'(m_axi_arvalid), 64'd0);
    check("t4_n_ar_after_rlast", 64'(hs_addr.size()), 64'd5);
    if (hs_addr.size() == 5) check("t4_hs5_cycle", 64'(hs_cyc[4] - t0), 64'd11);
    r_due_q.push_back(cyc);
    step();
    check("t5_arvalid", 64'(m_axi_arvalid), 64'd1);
    r_due_q.push_back(cyc);
    step();
    m_axi_arready = 1'b0;
    check("t5_same_cycle_count", 64'(dbg_outstanding), 64'd3);
    check("t5_n_ar", 64'(hs_addr.size()), 64'd6);
    ctrl_start = 1'b1;
    ctrl_addr_offset = 64'hDEAD0000;
    ctrl_xfer_size_in_bytes = 32'd64;
    step();
    ctrl_start = 1'b0;
    m_axi_arready = 1'b1;
    drain_mode = 1'b1;
    wait_done(200, "t4");
    drain_mode = 1'b0;
    check("t4_n_ar_total", 64'(hs_addr.size()), 64'd8);
    if (hs_addr.size() == 8) begin
      check("t4_last_addr", hs_addr[7], 64'h101C00);
      check("t4_last_len", 64'(hs_len[7]), 64'd15);
    end

    // RLAST while idle
    d = done_count;
    r_due_q.push_back(cyc);
    step(); step(); step();
    check("t5_idle_rlast_count", 64'(dbg_outstanding), 64'd0);
    check("t5_idle_rlast_no_done", 64'(done_count), 64'(d));

    // maximum size: counts must not truncate; abandoned by reset
    clr_logs();
    auto_r = 1'b0;
    d = done_count;
    start_xfer(64'h0, 32'hFFFF_FFFF, t0);
    repeat (7) step();
    check("t6_max_n_ar", 64'(hs_addr.size()), 64'd4);
    check("t6_max_no_done", 64'(done_count), 64'(d));
    if (hs_addr.size() == 4) begin
      check("t6_max_len0", 64'(hs_len[0]), 64'd15);
      check("t6_max_addr3", hs_addr[3], 64'hC00);
    end
    ap_rst_n = 1'b0;
    r_due_q.delete();
    step();
    ap_rst_n = 1'b1;
    check_reset_outputs("t6_max_reset");

    // reset after 2 of 4 ARs, then a fresh transfer
    clr_logs();
    auto_r = 1'b1;
    m_axi_arready = 1'b1;
    start_xfer(64'h40000, 32'd4096, t0);
    step(); step(); step();
    check("t6_n_ar_before_reset", 64'(hs_addr.size()), 64'd2);
    m_axi_arready = 1'b0;
    ap_rst_n = 1'b0;
    r_due_q.delete();
    step();
    ap_rst_n = 1'b1;
    check_reset_outputs("t6_mid_reset");
    run_xfer(64'h80000, 32'd2048, 2, 8'd15, 14, "t6_fresh");

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout at cycle %0d, expected bench completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
